// File: rtl/eq_cascade_engine.sv
// eq_cascade_engine: N_BANDS-stage Direct-Form-I biquad cascade over N_CH
// channels, sharing one multiply-accumulate unit across every band/channel.
// Each band/channel pair takes 5 MAC cycles plus 1 write-back cycle.
// Coefficients are written into a shadow bank, which is copied to the active
// bank when a frame is accepted, so a frame in flight never sees a write.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid / o_ready       frame input handshake (o_ready = engine idle)
//   i_data                  packed input frame, channel c at [c*DATA_W +: DATA_W]
//   o_valid / o_data        one-cycle done pulse; o_data held until next pulse
//   i_coef_we/band/sel/val  shadow coefficient write (sel 0..4 = b0,b1,b2,a1,a2)
//   i_clear                 zero filter history (deferred while a frame runs)
module eq_cascade_engine #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 18,
  parameter int Q_FRAC  = 14,
  parameter int N_BANDS = 6,
  parameter int N_CH    = 2,
  localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  output logic                     o_valid,
  output logic [N_CH*DATA_W-1:0]   o_data,
  input  logic                     i_coef_we,
  input  logic [BAND_W-1:0]        i_coef_band,
  input  logic [2:0]               i_coef_sel,
  input  logic [COEF_W-1:0]        i_coef_val,
  input  logic                     i_clear
);
  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(1) << (Q_FRAC - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic signed [COEF_W-1:0] UNITY   = COEF_W'(1 << Q_FRAC);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic signed [COEF_W-1:0] r_shadow [N_BANDS][5];
  logic signed [COEF_W-1:0] r_active [N_BANDS][5];
  logic signed [COEF_W-1:0] w_shadow_nxt [N_BANDS][5];
  logic signed [DATA_W-1:0] r_x1 [N_BANDS][N_CH];
  logic signed [DATA_W-1:0] r_x2 [N_BANDS][N_CH];
  logic signed [DATA_W-1:0] r_y1 [N_BANDS][N_CH];
  logic signed [DATA_W-1:0] r_y2 [N_BANDS][N_CH];
  logic signed [DATA_W-1:0] r_cur [N_CH];   // running value per channel through the cascade
  logic signed [DATA_W-1:0] w_in  [N_CH];
  logic signed [ACC_W-1:0]  r_acc;
  logic [2:0]               r_k;
  logic [BAND_W-1:0]        r_band;
  logic [CH_W-1:0]          r_ch;
  logic                     r_clr_pend;
  logic [N_CH*DATA_W-1:0]   r_odata;

  logic                     w_accept, w_coef_ok, w_last_pair, w_hist_clr;
  logic signed [COEF_W:0]   w_coef;
  logic signed [DATA_W-1:0] w_dat;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_rnd, w_shr;
  logic signed [DATA_W-1:0] w_y;

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign w_in[c] = i_data[c*DATA_W +: DATA_W];
  end

  assign w_accept    = i_valid && (r_state == S_IDLE);
  assign w_coef_ok   = i_coef_we && (32'(i_coef_band) < N_BANDS) && (i_coef_sel <= 3'd4);
  assign w_last_pair = (32'(r_band) == N_BANDS - 1) && (32'(r_ch) == N_CH - 1);
  // Idle clear is immediate; any clear seen while busy waits for S_DONE->S_IDLE.
  assign w_hist_clr  = ((r_state == S_IDLE) && i_clear && !w_accept) ||
                       ((r_state == S_DONE) && (r_clr_pend || i_clear));
  assign o_data      = r_odata;

  // FSM
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_nxt = S_MAC;
      end
      S_MAC:  if (r_k == 3'd4) w_state_nxt = S_WB;
      S_WB:   w_state_nxt = w_last_pair ? S_DONE : S_MAC;
      S_DONE: begin
        o_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Coefficient banks; a write landing on the accept edge is part of the copy.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_coef_ok) w_shadow_nxt[i_coef_band][i_coef_sel] = i_coef_val;
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int b = 0; b < N_BANDS; b++)
        for (int s = 0; s < 5; s++) begin
          r_shadow[b][s] <= (s == 0) ? UNITY : '0;
          r_active[b][s] <= (s == 0) ? UNITY : '0;
        end
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_accept) r_active <= w_shadow_nxt;
    end

  // MAC operand select; feedback terms negated with one guard bit so -min fits.
  always_comb begin
    w_coef = '0;
    w_dat  = '0;
    case (r_k)
      3'd0: begin w_coef =  {r_active[r_band][0][COEF_W-1], r_active[r_band][0]}; w_dat = r_cur[r_ch];        end
      3'd1: begin w_coef =  {r_active[r_band][1][COEF_W-1], r_active[r_band][1]}; w_dat = r_x1[r_band][r_ch]; end
      3'd2: begin w_coef =  {r_active[r_band][2][COEF_W-1], r_active[r_band][2]}; w_dat = r_x2[r_band][r_ch]; end
      3'd3: begin w_coef = -{r_active[r_band][3][COEF_W-1], r_active[r_band][3]}; w_dat = r_y1[r_band][r_ch]; end
      3'd4: begin w_coef = -{r_active[r_band][4][COEF_W-1], r_active[r_band][4]}; w_dat = r_y2[r_band][r_ch]; end
      default: ;
    endcase
  end

  assign w_prod = w_coef * w_dat;
  assign w_rnd  = r_acc + RND;
  assign w_shr  = w_rnd >>> Q_FRAC;
  assign w_y    = (w_shr > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                  (w_shr < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : w_shr[DATA_W-1:0];

  // Sequencing, accumulator, working samples, output register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_k        <= '0;
      r_band     <= '0;
      r_ch       <= '0;
      r_acc      <= '0;
      r_clr_pend <= 1'b0;
      r_odata    <= '0;
      for (int c = 0; c < N_CH; c++) r_cur[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_k    <= '0;
          r_band <= '0;
          r_ch   <= '0;
          r_cur  <= w_in;
          if (i_clear) r_clr_pend <= 1'b1;
        end
        S_MAC: begin
          r_acc <= ((r_k == 3'd0) ? '0 : r_acc) +
                   {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
          r_k   <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
          if (i_clear) r_clr_pend <= 1'b1;
        end
        S_WB: begin
          r_cur[r_ch] <= w_y;
          if (i_clear) r_clr_pend <= 1'b1;
          if (w_last_pair) begin
            for (int c = 0; c < N_CH; c++)
              r_odata[c*DATA_W +: DATA_W] <= (CH_W'(c) == r_ch) ? w_y : r_cur[c];
          end else if (32'(r_ch) == N_CH - 1) begin
            r_ch   <= '0;
            r_band <= r_band + BAND_W'(1);
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        S_DONE: r_clr_pend <= 1'b0;
        default: ;
      endcase
    end

  // Filter history
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst || w_hist_clr) begin
      for (int b = 0; b < N_BANDS; b++)
        for (int c = 0; c < N_CH; c++) begin
          r_x1[b][c] <= '0;
          r_x2[b][c] <= '0;
          r_y1[b][c] <= '0;
          r_y2[b][c] <= '0;
        end
    end else if (r_state == S_WB) begin
      r_x2[r_band][r_ch] <= r_x1[r_band][r_ch];
      r_x1[r_band][r_ch] <= r_cur[r_ch];
      r_y2[r_band][r_ch] <= r_y1[r_band][r_ch];
      r_y1[r_band][r_ch] <= w_y;
    end

endmodule

// File: doc/eq_cascade_engine.md
Name: eq_cascade_engine

Overview:
- Parametrised successor to the fixed six-band equaliser.
- Implements an N_BANDS-stage Direct-Form-I biquad cascade for N_CH channels using one time-multiplexed multiply-accumulate unit.
- Coefficients are runtime-writable through a shadow/active register bank.
- Sits between the audio receive path and the DAC/visualiser path: one multichannel sample frame in, one filtered frame out.

Parameters:
- DATA_W, 16, signed sample width per channel.
- COEF_W, 18, signed coefficient width.
- Q_FRAC, 14, coefficient fractional bits (coefficient 1.0 = 1<<Q_FRAC).
- N_BANDS, 6, number of cascaded biquads.
- N_CH, 2, channels processed per frame.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  input frame valid.
- o_ready  out  1  engine idle, can accept a frame.
- i_data  in  N_CH*DATA_W  packed input frame; channel c is bits [c*DATA_W +: DATA_W].
- o_valid  out  1  one-cycle pulse, o_data updated.
- o_data  out  N_CH*DATA_W  packed filtered frame, held until the next o_valid.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_band  in  $clog2(N_BANDS)  target band.
- i_coef_sel  in  3  coefficient select: 0 b0, 1 b1, 2 b2, 3 a1, 4 a2.
- i_coef_val  in  COEF_W  signed coefficient value.
- i_clear  in  1  request to zero all filter history.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous, active-high.
- Reset values:
  - state S_IDLE; o_ready=1; o_valid=0; o_data=0.
  - All history (x1,x2,y1,y2 per band per channel) = 0.
  - Shadow and active b0 = 1<<Q_FRAC; all other coefficients = 0 (every band is pass-through).
  - Clear-pending flag = 0.
- FSM states: S_IDLE, S_MAC, S_WB, S_DONE.
  - S_IDLE: o_ready=1. On i_valid&&o_ready:
    - latch i_data;
    - copy shadow coefficients to active;
    - set band=0, ch=0;
    - go to S_MAC.
  - S_MAC: 5 cycles, one product per cycle, order b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2. Accumulate at ACC_W = DATA_W+COEF_W+3 bits, signed, no wrap.
  - S_WB (1 cycle):
    - y = (acc + (1<<(Q_FRAC-1))) >>> Q_FRAC, saturated to DATA_W (max 2^(DATA_W-1)-1, min -2^(DATA_W-1)).
    - Update history: x2<=x1, x1<=x, y2<=y1, y1<=y.
    - y becomes the input x of the next band for the same channel.
    - Advance ch first, then band.
    - After the last ch/band pair, go to S_DONE; otherwise return to S_MAC.
  - S_DONE (1 cycle): o_valid=1, o_data=final outputs, o_ready=0; next state S_IDLE.
- Latency: o_valid is high exactly 6*N_CH*N_BANDS+1 cycles after the accepting edge (73 at defaults). o_ready is low from the cycle after acceptance through S_DONE.
- i_valid while o_ready=0: ignored, no buffering. The source must hold i_valid until accepted.
- Coefficient writes:
  - Accepted in any state and written to the shadow bank only. A frame in flight is never affected.
  - i_coef_band >= N_BANDS or i_coef_sel > 4: write ignored.
  - Write in the same cycle as frame acceptance: the new value is included in the shadow-to-active copy.
- i_clear:
  - In S_IDLE without simultaneous acceptance: history zeroed next edge.
  - Otherwise: sets the pending flag. History is zeroed on S_DONE->S_IDLE, after the current frame completes with its old history. The flag is then cleared.
  - i_clear and acceptance in the same cycle: the frame runs with the old history; the clear is deferred.
- Reset mid-frame: immediate abort. o_valid never pulses for the aborted frame. All values return to their reset values.
- Saturation applies at every band output, so intermediate bands cannot overflow downstream.

Test Plan:
- Pass-through after reset: frame ch0=0x1234, ch1=0x8000 -> o_data identical, o_valid exactly 73 cycles after acceptance, o_ready=0 in between, o_valid one cycle wide.
- Gain and saturation:
  - Setup: write band 2 b0=0x08000 (2.0).
  - ch0=0x3000 -> 0x6000.
  - ch0=0x5000 -> 0x7FFF.
  - ch1=0xB000 -> 0x8000.
- Recursion:
  - Setup: band 0 a1 = -0x02000 (-0.5).
  - Stimulus: impulse 0x4000 then zero frames on ch0.
  - Expected ch0 outputs: 0x4000, 0x2000, 0x1000, 0x0800.
  - Expected ch1: stays 0 (channel histories independent).
- Shadow timing: write band 0 b0=0 during S_MAC of frame N -> frame N output unchanged (pass-through), frame N+1 output 0.
- Deferred clear:
  - Setup: a1 = -0.5 on band 0 with history nonzero.
  - Stimulus: pulse i_clear mid-frame.
  - Expected: current frame still uses the old history; next zero-input frame outputs 0.
- Async reset mid-frame: assert i_rst at cycle 30 -> o_valid=0, o_ready=1 and o_data=0 immediately, no output pulse; subsequent frame 0x0100 passes through unchanged (coefficients restored).
